// File: rtl/tick_pkg.sv
// Shared constants and types for the maze-game tick scheduler.
package tick_pkg;

    localparam int CH_PLAYER = 32'sd0;
    localparam int CH_OBS    = 32'sd1;

    localparam int unsigned CLK_HZ            = 32'd50_000_000;
    localparam int unsigned DEF_PERIOD_PLAYER = CLK_HZ;          // 1 Hz
    localparam int unsigned DEF_PERIOD_OBS    = CLK_HZ * 32'd5;  // 0.2 Hz

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: programmable period register, free-running counter and
// a single-cycle expiry strobe (combinational, valid in the expiry cycle).
module tick_chan #(
    parameter int          CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 32'd1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pause,
    input  logic             we,
    input  logic [CNT_W-1:0] wdata,
    output logic             expire
);

    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] cnt_r;
    logic             hit_s;

    // Comparing against period-1 before incrementing keeps the counter from wrapping.
    assign hit_s  = (period_r != '0) && (cnt_r == (period_r - CNT_W'(1'b1)));
    assign expire = hit_s && !pause && !we;

    // Period register and counter; a config write restarts the count and masks expiry.
    always_ff @(posedge clk) begin
        if (clr) begin
            period_r <= CNT_W'(DEF_PERIOD);
            cnt_r    <= '0;
        end else if (we) begin
            period_r <= wdata;
            cnt_r    <= '0;
        end else if ((period_r == '0) || pause) begin
            period_r <= period_r;
            cnt_r    <= cnt_r;
        end else if (hit_s) begin
            period_r <= period_r;
            cnt_r    <= '0;
        end else begin
            period_r <= period_r;
            cnt_r    <= cnt_r + CNT_W'(1'b1);
        end
    end

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler with round-robin req/ack arbitration.
// Optional per-channel grant statistics when TICK_SCHED_STATS_EN is defined.
module tick_sched
    import tick_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEF_PERIOD0 = DEF_PERIOD_PLAYER,
    parameter int unsigned DEF_PERIOD1 = DEF_PERIOD_OBS,
    localparam int         CH_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              pause,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    output logic              move_req,
    output logic [CH_W-1:0]   move_ch,
    input  logic              move_ack,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun,
    input  logic              ovr_clr
`ifdef TICK_SCHED_STATS_EN
    ,
    input  logic [CH_W-1:0]   stat_ch,
    output logic [15:0]       stat_cnt
`endif
);

    arb_state_t        state_r;
    logic [CH_W-1:0]   ptr_r;
    logic [NUM_CH-1:0] expire_s;
    logic [NUM_CH-1:0] ack_hit_s;
    logic              ack_s;
    logic [CH_W-1:0]   pick_s;

    // First set request strictly after ptr, wrapping around NUM_CH.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [CH_W-1:0]   ptr);
        logic [CH_W:0] idx;
        logic          found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(NUM_CH)) begin
                idx = idx - (CH_W+1)'(NUM_CH);
            end else begin
                idx = idx;
            end
            if (!found && req[idx[CH_W-1:0]]) begin
                rr_pick = idx[CH_W-1:0];
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_chan #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD ((i < CH_OBS) ? DEF_PERIOD0 : DEF_PERIOD1)
        ) u_chan (
            .clk    (clk),
            .clr    (clr),
            .pause  (pause),
            .we     (cfg_we && (cfg_ch == CH_W'(i))),
            .wdata  (cfg_period),
            .expire (expire_s[i])
        );
    end

    assign ack_s     = move_req && move_ack && (state_r == GRANT);
    assign ack_hit_s = ack_s ? (NUM_CH'(1'b1) << move_ch) : '0;
    assign pick_s    = rr_pick(pending, ptr_r);

    // Pending/overrun flags: a new tick wins over both ack-clear and ovr_clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= expire_s | (pending & ~ack_hit_s);
            overrun <= (expire_s & pending & ~ack_hit_s) | (overrun & {NUM_CH{~ovr_clr}});
        end
    end

    // Grant FSM: one request at a time, at least one IDLE cycle between grants.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r  <= IDLE;
            move_req <= 1'b0;
            move_ch  <= CH_W'(CH_PLAYER);
            ptr_r    <= CH_W'(NUM_CH - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (|pending) begin
                        move_ch  <= pick_s;
                        move_req <= 1'b1;
                        state_r  <= GRANT;
                    end else begin
                        move_req <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                GRANT: begin
                    if (move_ack) begin
                        ptr_r    <= move_ch;
                        move_req <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        move_req <= 1'b1;
                        state_r  <= GRANT;
                    end
                end
                default: begin
                    move_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

`ifdef TICK_SCHED_STATS_EN
    logic [15:0] stat_r [NUM_CH];

    // Saturating completed-grant counters with a registered read port.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stat_r[i] <= 16'd0;
            end
            stat_cnt <= 16'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ack_hit_s[i] && (stat_r[i] != 16'hFFFF)) begin
                    stat_r[i] <= stat_r[i] + 16'd1;
                end else begin
                    stat_r[i] <= stat_r[i];
                end
            end
            if (int'(stat_ch) < NUM_CH) begin
                stat_cnt <= stat_r[stat_ch];
            end else begin
                stat_cnt <= 16'd0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: cycle model plus grant scoreboard.
module tb_tick_sched;

    logic       clk;
    logic       clr;
    logic       pause;
    logic       cfg_we;
    logic [0:0] cfg_ch;
    logic [31:0] cfg_period;
    logic       move_req;
    logic [0:0] move_ch;
    logic       move_ack;
    logic [1:0] pending;
    logic [1:0] overrun;
    logic       ovr_clr;
`ifdef TICK_SCHED_STATS_EN
    logic [0:0]  stat_ch;
    logic [15:0] stat_cnt;
`endif

    tick_sched #(
        .NUM_CH      (2),
        .CNT_W       (32),
        .DEF_PERIOD0 (32'd4),
        .DEF_PERIOD1 (32'd10)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .pause      (pause),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .move_req   (move_req),
        .move_ch    (move_ch),
        .move_ack   (move_ack),
        .pending    (pending),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
`ifdef TICK_SCHED_STATS_EN
        ,
        .stat_ch    (stat_ch),
        .stat_cnt   (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
    } exp_t;

    exp_t sb[$];
    int   gnt_ch[$];
    int   gnt_cyc[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ack_mode = 0;   // 0: ack while req, 1: ack held low, 2: driven by sequence
    int   ack0 = 0;
    int   n_gnt = 0;
    int   n_gnt1 = 0;
    logic prev_req = 1'b0;

    int         m_period[2];
    int         m_cnt[2];
    logic [1:0] m_pend;
    logic [1:0] m_ovr;
    logic       m_req;
    int         m_ch;
    int         m_ptr;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model of one clock edge, written for the two-channel case.
    task automatic model_update();
        logic [1:0] exp_v;
        logic [1:0] hit_v;
        logic [1:0] pend_n;
        logic [1:0] ovr_n;
        logic       ack_v;
        int         pick;
        if (clr) begin
            m_period[0] = 4;
            m_period[1] = 10;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            m_pend = 2'b00;
            m_ovr = 2'b00;
            m_req = 1'b0;
            m_ch = 0;
            m_ptr = 1;
        end else begin
            ack_v = m_req && move_ack;
            exp_v = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_period[i] = int'(cfg_period);
                    m_cnt[i] = 0;
                end else if (m_period[i] == 0 || pause) begin
                    m_cnt[i] = m_cnt[i];
                end else if (m_cnt[i] == m_period[i] - 1) begin
                    m_cnt[i] = 0;
                    exp_v[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            hit_v = 2'b00;
            if (ack_v) hit_v[m_ch] = 1'b1;
            pend_n = exp_v | (m_pend & ~hit_v);
            ovr_n = (exp_v & m_pend & ~hit_v) | (ovr_clr ? 2'b00 : m_ovr);
            if (!m_req) begin
                if (m_pend != 2'b00) begin
                    pick = m_pend[(m_ptr + 1) % 2] ? (m_ptr + 1) % 2 : m_ptr;
                    m_ch = pick;
                    m_req = 1'b1;
                    sb.push_back('{cyc + 1, pick});
                end
            end else if (ack_v) begin
                m_ptr = m_ch;
                m_req = 1'b0;
            end
            m_pend = pend_n;
            m_ovr = ovr_n;
        end
    endtask

    task automatic step();
        exp_t e;
        if (ack_mode == 0) move_ack = move_req;
        else if (ack_mode == 1) move_ack = 1'b0;
        if (move_req === 1'b1 && move_ack && move_ch == 1'b0) ack0++;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        chk("pending", int'(pending), int'(m_pend));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("move_req", int'(move_req), int'(m_req));
        chk("move_ch", int'(move_ch), m_ch);
        if (move_req === 1'b1 && !prev_req) begin
            n_gnt++;
            if (move_ch == 1'b1) n_gnt1++;
            gnt_ch.push_back(int'(move_ch));
            gnt_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("sb_unexpected_grant", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_grant_ch", int'(move_ch), e.ch);
                chk("sb_grant_cyc", cyc, e.cyc);
            end
        end
        prev_req = move_req;
    endtask

    task automatic cfg(input int ch, input int p);
        cfg_we = 1'b1;
        cfg_ch = 1'(ch);
        cfg_period = 32'(p);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget && move_req !== 1'b1; i++) step();
        chk("wait_req", int'(move_req), 1);
    endtask

    initial begin
        int g;
        int idx;
        clr = 1'b1; pause = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0;
        cfg_period = 32'd0; move_ack = 1'b0; ovr_clr = 1'b0;
`ifdef TICK_SCHED_STATS_EN
        stat_ch = 1'b0;
`endif
        repeat (3) step();
        chk("rst_pending", int'(pending), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_req", int'(move_req), 0);
        chk("rst_ch", int'(move_ch), 0);

        // Defaults: ch0 every 4 cycles, first request at E+2.
        clr = 1'b0;
        repeat (4) step();
        chk("dflt_pend0", int'(pending), 1);
        chk("dflt_req_early", int'(move_req), 0);
        step();
        chk("dflt_req", int'(move_req), 1);
        chk("dflt_ch", int'(move_ch), 0);
        repeat (45) step();
        chk("dflt_ch1_grants", n_gnt1, 4);

        // Coincident expiries: ch0 first, ch1 after one idle cycle, ch0 first again.
        pause = 1'b1;
        cfg(0, 8);
        cfg(1, 8);
        repeat (6) step();
        idx = gnt_ch.size();
        pause = 1'b0;
        repeat (24) step();
        if (gnt_ch.size() >= idx + 4) begin
            chk("coinc_first", gnt_ch[idx], 0);
            chk("coinc_second", gnt_ch[idx + 1], 1);
            chk("coinc_gap", gnt_cyc[idx + 1] - gnt_cyc[idx], 2);
            chk("coinc_third", gnt_ch[idx + 2], 0);
            chk("coinc_fourth", gnt_ch[idx + 3], 1);
        end else begin
            chk("coinc_count", gnt_ch.size() - idx, 4);
        end

        // Overrun while the engine stalls.
        cfg(1, 0);
        cfg(0, 4);
        ack_mode = 1;
        wait_req(20);
        g = n_gnt;
        repeat (9) step();
        chk("ovr_set", int'(overrun[0]), 1);
        chk("ovr_pend", int'(pending[0]), 1);
        chk("ovr_single_grant", n_gnt, g);
        ack_mode = 0;
        step();
        cfg(0, 0);
        repeat (6) step();
        chk("ovr_sticky", int'(overrun[0]), 1);
        chk("ovr_drained", int'(pending), 0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr", int'(overrun), 0);

        // Mid-count period write restarts the counter.
        cfg(1, 10);
        repeat (4) step();
        cfg(1, 3);
        repeat (2) step();
        chk("cfg_not_yet", int'(pending[1]), 0);
        step();
        chk("cfg_expire", int'(pending[1]), 1);
        ack_mode = 1;
        cfg(1, 0);
        chk("cfg0_keeps_pend", int'(pending[1]), 1);
        chk("cfg0_req_ch", int'(move_ch), 1);
        ack_mode = 0;
        repeat (2) step();
        g = n_gnt;
        repeat (20) step();
        chk("cfg0_no_grant", n_gnt, g);
        chk("cfg0_idle", int'(pending), 0);

        // Pause freezes counters while an outstanding grant completes.
        cfg(0, 4);
        ack_mode = 1;
        wait_req(20);
        pause = 1'b1;
        ack_mode = 0;
        g = n_gnt;
        repeat (20) step();
        chk("pause_pend", int'(pending), 0);
        chk("pause_req", int'(move_req), 0);
        chk("pause_grants", n_gnt, g);
        pause = 1'b0;

        // Reset during GRANT; the late ack must be ignored.
        ack_mode = 1;
        wait_req(20);
        clr = 1'b1;
        step();
        chk("clr_req", int'(move_req), 0);
        chk("clr_pend", int'(pending), 0);
        clr = 1'b0;
        ack_mode = 2;
        move_ack = 1'b1;
        step();
        move_ack = 1'b0;
        ack_mode = 0;
        chk("late_ack_req", int'(move_req), 0);
        repeat (3) step();
        chk("clr_restart_pend", int'(pending), 1);
        step();
        chk("clr_restart_req", int'(move_req), 1);
        chk("clr_restart_ch", int'(move_ch), 0);

`ifdef TICK_SCHED_STATS_EN
        clr = 1'b1;
        step();
        clr = 1'b0;
        ack0 = 0;
        cfg(1, 0);
        for (int i = 0; i < 200 && ack0 < 5; i++) step();
        chk("stat_acks", ack0, 5);
        stat_ch = 1'b0;
        step();
        chk("stat_cnt0", int'(stat_cnt), 5);
`endif

        repeat (4) step();
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/tick_sched.md
Name: tick_sched

Overview:
- Multi-channel programmable tick scheduler for the maze game's timed actions (player step, moving-obstacle step).
- Each channel counts master-clock cycles to a run-time programmable period and raises a pending request when the period expires.
- A round-robin arbiter serialises pending requests onto a single req/ack port feeding the shared maze-grid move engine.
- Sits between the master-clock domain and the move engine; replaces the fixed 1 Hz and 0.2 Hz pulse generators.

Parameters:
- NUM_CH, 2, number of tick channels (2..8); channel 0 = player, channel 1 = moving obstacle.
- CNT_W, 32, width of each period register and counter.
- DEF_PERIOD0, 50000000, reset period of channel 0 in clk cycles (1 Hz at 50 MHz).
- DEF_PERIOD1, 250000000, reset period of channels 1..NUM_CH-1.

Ports:
- clk  in  1  master clock, 50 MHz.
- clr  in  1  reset; synchronous, active-high.
- pause  in  1  high freezes all channel counters; pending state and arbitration continue.
- cfg_we  in  1  one-cycle period write strobe.
- cfg_ch  in  CH_W  channel written; CH_W = max(1, clog2(NUM_CH)).
- cfg_period  in  CNT_W  new period; 0 disables the channel.
- move_req  out  1  request to the move engine.
- move_ch  out  CH_W  channel being served; stable while move_req is high.
- move_ack  in  1  move engine completion; sampled only while move_req is high.
- pending  out  NUM_CH  per-channel pending flags.
- overrun  out  NUM_CH  sticky flag: the channel expired while already pending.
- ovr_clr  in  1  clears all overrun bits.

Behaviour:
- Reset (clr high at a clk edge):
  - Counters = 0; periods = DEF_* values; pending = 0; overrun = 0.
  - move_req = 0, move_ch = 0; round-robin pointer = NUM_CH-1, so channel 0 has priority first.
  - clr overrides all other inputs. A request in flight is dropped; any ack arriving afterwards is ignored.
- Counter, per channel:
  - If period == 0 or pause: hold.
  - Else if cnt == period-1: cnt <= 0 and this is the expiry cycle E.
  - Else cnt <= cnt + 1.
  - Result: one expiry every `period` cycles.
- Expiry:
  - pending[ch] is set at the edge ending E (visible in E+1).
  - If pending[ch] was already 1 and is not being cleared by ack in E, set overrun[ch]; the pending request is not duplicated.
  - Expiry and ack for the same channel in the same cycle: pending stays 1 (new tick), no overrun.
- Config write (cfg_we):
  - period[cfg_ch] <= cfg_period; cnt[cfg_ch] <= 0. The write takes priority over that cycle's expiry.
  - Writes to cfg_ch >= NUM_CH are ignored.
  - Writing 0 does not clear an existing pending flag; that request is still served.
- Arbiter FSM, two states:
  - IDLE: if any pending bit is set, pick the first set bit scanning from ptr+1 upward with wrap. Next cycle: move_ch <= pick, move_req <= 1, go to GRANT.
  - GRANT: hold move_req and move_ch. On move_ack: pending[move_ch] cleared, ptr <= move_ch, move_req <= 0, go to IDLE.
  - At least one IDLE cycle separates grants.
  - Minimum latency from expiry cycle E to move_req high is 2 cycles (E+2).
- ovr_clr clears overrun; an overrun set in the same cycle wins.
- Counter arithmetic is CNT_W-bit unsigned. The counter cannot wrap past period-1, because it compares against period-1 before incrementing.

Optional Feature:
- Macro: TICK_SCHED_STATS_EN.
- Defined: adds input stat_ch [CH_W] and output stat_cnt [16].
  - One 16-bit saturating counter per channel, incremented on each completed grant (ack) and holding at 0xFFFF.
  - stat_cnt is a registered read of stat_ch, 1-cycle latency.
  - Counters are cleared by clr.
- Undefined: no stat ports, no counters; all other behaviour is identical.

Decomposition:
- Shared package tick_pkg holds:
  - the channel index constants CH_PLAYER=0, CH_OBS=1;
  - the arbiter state enum {IDLE, GRANT};
  - the 50 MHz-based default period constants.
- One natural sub-module, tick_chan: period register plus counter plus expiry pulse, instantiated NUM_CH times.
- The arbiter, pending flags and overrun flags stay in the top module.

Test Plan:
- Reset defaults: DEF_PERIOD0=4, DEF_PERIOD1=10, move_ack tied high one cycle after req.
  - Expect ch0 expiry every 4 cycles, move_req at E+2 with move_ch=0.
  - Expect ch1 requests every 10 cycles.
- Simultaneous pending: force both channels to expire in the same cycle.
  - Expect ch0 granted first, then ch1 after one IDLE cycle.
  - On the next coincidence, ch0 is still first, because ptr was left at 1.
- Overrun: hold move_ack=0 for 9 cycles with period0=4.
  - Expect overrun[0]=1 and pending[0]=1, with a single grant after the ack.
  - ovr_clr then clears overrun[0].
- Config: write cfg_ch=1, cfg_period=3 mid-count.
  - Expect cnt1 reset and expiry exactly 3 cycles after the write.
  - A subsequent write of period 0 stops further ch1 expiries; an already pending ch1 is still granted.
- Pause and reset: hold pause for 20 cycles → no new expiries, and a pending grant still completes.
  - Then assert clr while in GRANT: move_req=0 next cycle, pending=0, and the late move_ack is ignored.
- Stats (TICK_SCHED_STATS_EN): 5 grants on ch0 → stat_ch=0 reads stat_cnt=5 one cycle later.
